// File: rtl/tt_um_serial_feeder.sv
// ---------------------------------------------------------------------------
// tt_um_serial_feeder
//   Serialises a captured byte onto sd with a programmable bit period, for
//   feeding a downstream 3-bit-group sequence detector.
//
// Ports
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   ena     : power-good, unused
//   ui_in   : [0] start (rising edge requests a frame), [1] lsb_first,
//             [2] repeat, [3] abort, [7:4] prescale P (bit = P+1 cycles)
//   uio_in  : data byte captured at frame start
//   uo_out  : [0] sd, [1] valid, [2] busy, [3] done, [6:4] bit_cnt, [7] grp
//   uio_out : tied 0
//   uio_oe  : tied 0 (uio is input only)
// ---------------------------------------------------------------------------
module tt_um_serial_feeder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic       start_q;
  logic [7:0] shreg;
  logic [7:0] data_r;
  logic       dir_r;
  logic [3:0] p_r;
  logic [3:0] div;
  logic [2:0] bit_cnt;

  logic start;
  logic start_edge;
  logic rpt;
  logic abort;

  logic unused_ena;
  assign unused_ena = ena;

  assign start      = ui_in[0];
  assign rpt        = ui_in[2];
  assign abort      = ui_in[3];
  assign start_edge = start & ~start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
      shreg   <= '0;
      data_r  <= '0;
      dir_r   <= 1'b0;
      p_r     <= '0;
      div     <= '0;
      bit_cnt <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            data_r  <= uio_in;
            shreg   <= uio_in;
            dir_r   <= ui_in[1];
            p_r     <= ui_in[7:4];
            // div takes the prescale being captured on this same edge
            div     <= ui_in[7:4];
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (div == 4'd0) begin
            div <= p_r;
            if (bit_cnt == 3'd7) begin
              if (rpt) begin
                shreg   <= data_r;
                bit_cnt <= '0;
              end else begin
                state <= DONE;
              end
            end else begin
              shreg   <= dir_r ? {1'b0, shreg[7:1]} : {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            div <= div - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from registers only; sd/bit_cnt/grp are gated by valid.
  logic       valid;
  logic       done;
  logic       sd;
  logic [2:0] cnt_o;
  logic       grp;

  always_comb begin
    valid = (state == SHIFT);
    done  = (state == DONE);
    sd    = 1'b0;
    cnt_o = '0;
    grp   = 1'b0;
    if (valid) begin
      sd    = dir_r ? shreg[0] : shreg[7];
      cnt_o = bit_cnt;
      grp   = (bit_cnt == 3'd0) || (bit_cnt == 3'd3) || (bit_cnt == 3'd6);
    end
  end

  assign uo_out  = {grp, cnt_o, done, valid, valid, sd};
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule
